vlsu_mem_port: RTL
==================

# vlsu_mem_port

Memory-side request port for the vector load/store unit. It sits between the vector LSU and the data OBI bus. It buffers word requests (address, byte enables, write flag, write data) issued by the LSU and drives them onto OBI. It tracks outstanding transactions and returns read data to the LSU in order, flagging reads apart from write acknowledges. It also gives the LSU an `idle_o` signal, so that "done" is reported only after every issued access has completed.

## Interface
- `DEPTH`, default 2: request FIFO depth, ≥1.
- `MAX_OUTSTANDING`, default 2: maximum granted-but-unanswered OBI transactions, ≥1.
- `clk` input 1: clock, rising edge.
- `n_reset` input 1: asynchronous, active-low reset.
- `req_valid_i` input 1: LSU request valid.
- `req_ready_o` output 1: port can accept a request.
- `req_addr_i` input 32: word address.
- `req_we_i` input 1: 1 = store, 0 = load.
- `req_be_i` input 4: byte enables.
- `req_wdata_i` input 32: store data.
- `rsp_valid_o` output 1: read data valid, one-cycle pulse, no backpressure.
- `rsp_rdata_o` output 32: read data.
- `idle_o` output 1: FIFO empty and zero outstanding.
- `err_o` output 1: sticky protocol error.
- `data_req_o` output 1: OBI request.
- `data_gnt_i` input 1: OBI grant.
- `data_rvalid_i` input 1: OBI response valid.
- `data_addr_o` output 32: OBI address.
- `data_we_o` output 1: OBI write enable.
- `data_be_o` output 4: OBI byte enables.
- `data_wdata_o` output 32: OBI write data.
- `data_rdata_i` input 32: OBI read data.

## Operation
- **Accept:** a request is accepted on a rising edge where `req_valid_i & req_ready_o`. `req_ready_o` = !fifo_full and does not depend on `req_valid_i`.
- **Issue:** `data_req_o` = !fifo_empty & (outstanding < MAX_OUTSTANDING).
  - `data_addr_o`, `data_we_o`, `data_be_o` and `data_wdata_o` come from the FIFO head.
  - All are 0 when `data_req_o` = 0.
- **OBI stability:** once `data_req_o` is high, the head fields and `data_req_o` stay stable until grant. Outstanding counter growth never deasserts a pending request, because the counter only increments on grant.
- **Grant:** on an edge with `data_req_o & data_gnt_i`:
  - the head is popped;
  - outstanding increments;
  - the head's `we` bit is pushed into the tag FIFO (depth MAX_OUTSTANDING).
- **Response:** on `data_rvalid_i` with outstanding > 0:
  - outstanding decrements and the tag FIFO pops;
  - `rsp_valid_o` = !tag_head (reads only);
  - `rsp_rdata_o` = `data_rdata_i` in the same cycle (combinational); otherwise it is 0.
  - Write acknowledges are consumed silently.
- **Grant and response in the same cycle:** the counter is unchanged and the tag FIFO pushes and pops in the same cycle.
- **Issue limit:** no issue while outstanding == MAX_OUTSTANDING. A response in that cycle does not allow same-cycle issue.
- **Push and pop in the same cycle** on a non-full FIFO are both performed.
- **Protocol error:** `data_rvalid_i` with outstanding == 0 is ignored, sets `err_o`, and leaves `rsp_valid_o` = 0. `err_o` clears only on reset.
- **Reset:** reset asserted mid-operation clears the FIFOs, counter and error immediately. The memory side is reset by the same `n_reset`.
- **Reset values:**
  - `req_ready_o` = 1 and `idle_o` = 1.
  - `data_req_o`, `rsp_valid_o` and `err_o` = 0.
  - All data outputs = 0.

## Timing
- **Default build:** a request accepted at edge N drives `data_req_o` from cycle N+1 (FIFO register latency 1).
- **Read round trip:** with gnt in the first request cycle and rvalid one cycle after grant, the read returns at cycle N+2.
- **Throughput:** one request per cycle while grants arrive every cycle and outstanding < MAX_OUTSTANDING.
- **`idle_o`:** combinational from FIFO-empty and counter==0. It rises in the cycle after the final response edge.

## Configuration
- **`VLSU_MEM_PORT_BYPASS_EN` defined:** when the FIFO is empty and outstanding < MAX_OUTSTANDING, `req_valid_i` drives `data_req_o` and the OBI fields combinationally from the `req_*` inputs (zero latency).
  - If `data_gnt_i` arrives in that cycle, the request is not written to the FIFO.
  - If it is not granted, it is written to the FIFO and re-presented from the head the next cycle with identical fields.
  - In the bypass case `idle_o` also requires !`req_valid_i`.
- **Undefined:** all requests pass through the FIFO (latency 1 as above).

## Structure
- **accelerator_pkg:**
  - `obi_req_t` packed struct: addr[31:0], we, be[3:0], wdata[31:0];
  - localparam `OBI_WORD_BYTES` = 4.
- **Sub-module `vlsu_fifo`:** parameterised width/depth synchronous FIFO with async active-low reset, push/pop/full/empty/head outputs.
  - Instantiated twice: request FIFO (`$bits(obi_req_t)` × DEPTH) and tag FIFO (1 × MAX_OUTSTANDING).
- **Top level:** counter width `$clog2(MAX_OUTSTANDING+1)`.

## Test plan
- **Single load:** push addr 0x100, be 0xF, gnt immediate, rvalid next cycle with rdata 0xDEADBEEF. Required: `rsp_valid_o` is a one-cycle pulse with 0xDEADBEEF, and `idle_o` returns to 1.
- **Single store:** push we=1, wdata 0x12345678, be 0x3. Required: OBI fields match; on rvalid, `rsp_valid_o` stays 0; `idle_o` rises.
- **Grant stall:** hold `data_gnt_i` = 0 for 3 cycles with 2 queued requests. Required:
  - `data_addr_o` and `data_req_o` stable all 3 cycles;
  - `req_ready_o` = 0 when DEPTH=2 is full;
  - requests issue in order after grant.
- **Outstanding limit (MAX_OUTSTANDING=2):** 3 loads, gnt always high, responses delayed 4 cycles. Required: the third `data_req_o` is held low until the first rvalid; 3 responses return in order with tags matching the request order.
- **Mixed interleave:** load, store, load with rvalid data A, B, C. Required: exactly two `rsp_valid_o` pulses, carrying A and C.
- **Error and reset:** spurious rvalid while idle sets `err_o`=1. Reset asserted with 1 request queued and 1 outstanding. Required: all outputs immediately return to their reset values.

Source files
------------

// File: rtl/accelerator_pkg.sv
// Shared types for the vector LSU memory port: the OBI request word carried
// through the request FIFO and onto the data bus.
package accelerator_pkg;

    localparam int OBI_WORD_BYTES = 4;

    typedef struct packed {
        logic [31:0]               addr;
        logic                      we;
        logic [OBI_WORD_BYTES-1:0] be;
        logic [31:0]               wdata;
    } obi_req_t;

endpackage

// File: rtl/vlsu_fifo.sv
// Width/depth parameterised synchronous FIFO with a registered storage array
// and an always-visible head entry; pushes while full and pops while empty are dropped.
module vlsu_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + PW'(1);
    endfunction

    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/vlsu_mem_port.sv
// Vector LSU memory port: queues word requests, drives them onto OBI, and returns
// read data in order. Optional zero-latency issue path: VLSU_MEM_PORT_BYPASS_EN.
module vlsu_mem_port
    import accelerator_pkg::*;
#(
    parameter int DEPTH           = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_addr_i,
    input  logic        req_we_i,
    input  logic [3:0]  req_be_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        idle_o,
    output logic        err_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i
);

    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OW-1:0] MAX_CNT = OW'(MAX_OUTSTANDING);

    obi_req_t      w_req_in;
    obi_req_t      w_head;
    obi_req_t      w_out;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic          w_fifo_push;
    logic          w_fifo_pop;
    logic          w_can_issue;
    logic          w_issue_fifo;
    logic          w_bypass;
    logic          w_grant;
    logic          w_rsp;
    logic          w_tag_head;
    logic          w_tag_full;
    logic          w_tag_empty;
    logic          w_tag_push;
    logic [OW-1:0] r_outstanding;
    logic          r_err;

    assign w_req_in = '{addr: req_addr_i, we: req_we_i, be: req_be_i, wdata: req_wdata_i};

    // Counter only grows on grant, so a pending request can never be withdrawn.
    assign w_can_issue  = (r_outstanding < MAX_CNT);
    assign w_issue_fifo = ~w_fifo_empty & w_can_issue;

    always_comb begin
        w_bypass = 1'b0;
`ifdef VLSU_MEM_PORT_BYPASS_EN
        w_bypass = w_fifo_empty & w_can_issue & req_valid_i;
`endif
        w_out = '0;
        if (w_issue_fifo) begin
            w_out = w_head;
        end else if (w_bypass) begin
            w_out = w_req_in;
        end
    end

    assign data_req_o   = w_issue_fifo | w_bypass;
    assign data_addr_o  = w_out.addr;
    assign data_we_o    = w_out.we;
    assign data_be_o    = w_out.be;
    assign data_wdata_o = w_out.wdata;

    assign w_grant     = data_req_o & data_gnt_i;
    assign req_ready_o = ~w_fifo_full;
    // A bypassed request that is granted immediately never enters the queue.
    assign w_fifo_push = req_valid_i & req_ready_o & ~(w_bypass & data_gnt_i);
    assign w_fifo_pop  = w_issue_fifo & data_gnt_i;

    vlsu_fifo #(
        .WIDTH ($bits(obi_req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_push  (w_fifo_push),
        .i_data  (w_req_in),
        .i_pop   (w_fifo_pop),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_head  (w_head)
    );

    // One tag per granted transaction records whether its response carries read data.
    assign w_rsp      = data_rvalid_i & (r_outstanding != '0);
    assign w_tag_push = w_grant & ~w_tag_full;

    vlsu_fifo #(
        .WIDTH (1),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk     (clk),
        .n_reset (n_reset),
        .i_push  (w_tag_push),
        .i_data  (w_out.we),
        .i_pop   (w_rsp),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty),
        .o_head  (w_tag_head)
    );

    assign rsp_valid_o = w_rsp & ~w_tag_empty & ~w_tag_head;
    assign rsp_rdata_o = rsp_valid_o ? data_rdata_i : 32'h0;
    assign err_o       = r_err;

`ifdef VLSU_MEM_PORT_BYPASS_EN
    assign idle_o = w_fifo_empty & (r_outstanding == '0) & ~req_valid_i;
`else
    assign idle_o = w_fifo_empty & (r_outstanding == '0);
`endif

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_outstanding <= '0;
            r_err         <= 1'b0;
        end else begin
            case ({w_grant, w_rsp})
                2'b10:   r_outstanding <= r_outstanding + OW'(1);
                2'b01:   r_outstanding <= r_outstanding - OW'(1);
                default: r_outstanding <= r_outstanding;
            endcase
            if (data_rvalid_i && (r_outstanding == '0)) r_err <= 1'b1;
        end
    end

endmodule
